snd_fft_seq: RTL and testbench
==============================

Name: snd_fft_seq

Overview:
Sample-rate sequencer for the FFT voice-change datapath. On each audio sample strobe it pops one 32-bit word from both the L and R sample FIFOs and presents them to the datapath as a held, registered pair. It then waits the datapath's fixed pipeline latency and captures the converted 16-bit L/R result with a one-cycle valid strobe. It sits between the input FIFOs and the FFT/IFFT datapath on one side, and the audio DAC interface on the other.

Parameters:
DP_LAT, 6, cycles from DP_LOAD to a valid DP_SND_L/R result; legal range 1..255.
MUTE_ON_UNDERRUN, 0, when 1 the outputs go to 16'h0 on underrun; when 0 they hold the last value.

Ports:
CLK  in  1  system clock
RST_X  in  1  synchronous active-low reset
ENABLE  in  1  sequencer enable, level
SMP_TICK  in  1  one-cycle sample-rate strobe
FIFO_EMPTY_L  in  1  L FIFO empty
FIFO_EMPTY_R  in  1  R FIFO empty
FIFO_RD_EN  out  1  shared pop strobe for both FIFOs
FIFO_DOUT_L  in  32  L FIFO data, valid the cycle after FIFO_RD_EN
FIFO_DOUT_R  in  32  R FIFO data, valid the cycle after FIFO_RD_EN
DP_DIN_L  out  32  registered datapath input L
DP_DIN_R  out  32  registered datapath input R
DP_LOAD  out  1  one-cycle strobe; new DP_DIN is valid this cycle
DP_SND_L  in  16  datapath result L
DP_SND_R  in  16  datapath result R
L_SNDDATA  out  16  captured output L
R_SNDDATA  out  16  captured output R
SND_VALID  out  1  one-cycle strobe; new L/R_SNDDATA is valid
BUSY  out  1  high in any state other than IDLE
UNDERRUN  out  1  one-cycle strobe on an underrun tick
OVERRUN  out  1  one-cycle strobe on an overrun tick
UNDERRUN_CNT  out  16  saturating count (feature-gated)
OVERRUN_CNT  out  16  saturating count (feature-gated)

Behaviour:
- Reset: synchronous, active-low, sampled on the CLK rising edge. While RST_X is low, every output is 0 and the state is IDLE. A reset mid-frame abandons the frame; no SND_VALID is issued for it.
- FSM states: IDLE, POP, LOAD, WAIT.
- IDLE: when SMP_TICK=1, ENABLE=1 and both EMPTY flags=0, assert FIFO_RD_EN for exactly this cycle and go to POP.
- IDLE underrun: when SMP_TICK=1, ENABLE=1 and either EMPTY flag=1, pulse UNDERRUN and do not pop.
  - With MUTE_ON_UNDERRUN=1, the next cycle L/R_SNDDATA=0 and SND_VALID pulses.
  - With MUTE_ON_UNDERRUN=0, the outputs hold and there is no SND_VALID.
- POP: register FIFO_DOUT_L/R into DP_DIN_L/R, load the down-counter with DP_LAT-1, and go to LOAD.
- LOAD: DP_LOAD=1 for this cycle only. If DP_LAT=1, go directly to capture (the WAIT zero-count action); otherwise go to WAIT.
- WAIT: decrement the counter each cycle. At count 0:
  - register DP_SND_L/R into L/R_SNDDATA;
  - SND_VALID=1 on the following cycle, aligned with the new data;
  - go to IDLE.
- Latency: SND_VALID rises exactly DP_LAT+2 cycles after the tick cycle. The FIFO_RD_EN cycle counts as 0.
- DP_DIN_L/R hold stable from POP until the next POP.
- Overrun: SMP_TICK=1 while not in IDLE pulses OVERRUN. The tick is dropped and not queued; the current frame completes normally.
- ENABLE=0 mid-frame: the frame completes, then the FSM stays in IDLE. Ticks with ENABLE=0 are ignored (no underrun, no overrun).
- SMP_TICK and entry into IDLE in the same cycle: the FSM is still non-IDLE in that cycle, so the tick counts as an overrun.
- FIFO_RD_EN is never asserted while either EMPTY flag is high.

Optional Feature:
SND_FFT_SEQ_STAT_EN
- Defined: UNDERRUN_CNT and OVERRUN_CNT increment on each corresponding strobe, saturate at 16'hFFFF, and reset to 0.
- Undefined: both ports are tied to 16'h0 and no counter logic is built.

Decomposition:
- Shared package snd_fft_pkg:
  - FSM state encoding (IDLE=0, POP=1, LOAD=2, WAIT=3);
  - SND_W=16 and FIFO_W=32 constants;
  - the default DP_LAT.
- One natural sub-module, snd_sat_cnt16: 16-bit saturating counter with inc/clear, instantiated twice under the macro.
- The FSM and the data registers stay in snd_fft_seq.

Test Plan:
- Reset, then a tick with both FIFOs non-empty (L=32'h0123_4567, R=32'h89AB_CDEF), DP_LAT=6 -> FIFO_RD_EN in cycle 0, DP_LOAD in cycle 2, DP_DIN_L/R equal the FIFO words, SND_VALID in cycle 8 with L/R_SNDDATA = model DP_SND values.
- Tick with FIFO_EMPTY_R=1 and MUTE_ON_UNDERRUN=0, after a prior output of 16'h1234 -> UNDERRUN pulse, no FIFO_RD_EN, no SND_VALID, L_SNDDATA stays 16'h1234. Repeat with MUTE=1 -> SND_VALID with outputs 16'h0.
- Second tick 3 cycles after the first (DP_LAT=6) -> OVERRUN pulse, only one FIFO_RD_EN, exactly one SND_VALID.
- ENABLE dropped in cycle 4 of a frame, then 3 more ticks -> that frame's SND_VALID is still issued; no further pops, no UNDERRUN/OVERRUN.
- RST_X low in the WAIT state -> next cycle all outputs 0 and BUSY=0; no SND_VALID for the aborted frame; the next tick runs a normal frame.
- With SND_FFT_SEQ_STAT_EN, 70000 underrun ticks -> UNDERRUN_CNT=16'hFFFF; after reset, 16'h0.

Source files
------------

// File: rtl/snd_fft_pkg.sv
// Shared types and constants for the FFT voice-change sample sequencer.
// Build option SND_FFT_SEQ_STAT_EN (see snd_fft_seq) adds underrun/overrun counters.
package snd_fft_pkg;

    localparam int SND_W      = 16;
    localparam int FIFO_W     = 32;
    localparam int DP_LAT_DEF = 6;
    localparam int LAT_CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_LOAD = 2'd2,
        ST_WAIT = 2'd3
    } seq_state_e;

endpackage

// File: rtl/snd_sat_cnt16.sv
// 16-bit saturating event counter with synchronous active-low reset and clear.
module snd_sat_cnt16 (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        clr_i,
    input  logic        inc_i,
    output logic [15:0] cnt_o
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/snd_fft_seq.sv
// Sample-rate sequencer: pops an L/R pair per tick, feeds the datapath, captures the result.
// Define SND_FFT_SEQ_STAT_EN to build the saturating underrun/overrun counters.
module snd_fft_seq
    import snd_fft_pkg::*;
#(
    parameter int DP_LAT           = DP_LAT_DEF,
    parameter int MUTE_ON_UNDERRUN = 0
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic        ENABLE,
    input  logic        SMP_TICK,
    input  logic        FIFO_EMPTY_L,
    input  logic        FIFO_EMPTY_R,
    output logic        FIFO_RD_EN,
    input  logic [31:0] FIFO_DOUT_L,
    input  logic [31:0] FIFO_DOUT_R,
    output logic [31:0] DP_DIN_L,
    output logic [31:0] DP_DIN_R,
    output logic        DP_LOAD,
    input  logic [15:0] DP_SND_L,
    input  logic [15:0] DP_SND_R,
    output logic [15:0] L_SNDDATA,
    output logic [15:0] R_SNDDATA,
    output logic        SND_VALID,
    output logic        BUSY,
    output logic        UNDERRUN,
    output logic        OVERRUN,
    output logic [15:0] UNDERRUN_CNT,
    output logic [15:0] OVERRUN_CNT
);

    localparam logic [LAT_CNT_W-1:0] LAT_M1 = LAT_CNT_W'(DP_LAT - 1);

    seq_state_e            state_q, state_d;
    logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
    logic [FIFO_W-1:0]     din_l_q, din_l_d;
    logic [FIFO_W-1:0]     din_r_q, din_r_d;
    logic [SND_W-1:0]      snd_l_q, snd_l_d;
    logic [SND_W-1:0]      snd_r_q, snd_r_d;
    logic                  snd_valid_q, snd_valid_d;

    logic tick_en;
    logic rd_en;
    logic underrun;
    logic overrun;
    logic dp_load;
    logic capture;

    assign tick_en = SMP_TICK & ENABLE;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        din_l_d     = din_l_q;
        din_r_d     = din_r_q;
        snd_l_d     = snd_l_q;
        snd_r_d     = snd_r_q;
        snd_valid_d = 1'b0;
        rd_en       = 1'b0;
        underrun    = 1'b0;
        dp_load     = 1'b0;
        capture     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tick_en) begin
                    if (!FIFO_EMPTY_L && !FIFO_EMPTY_R) begin
                        rd_en   = 1'b1;
                        state_d = ST_POP;
                    end else begin
                        underrun = 1'b1;
                        if (MUTE_ON_UNDERRUN != 0) begin
                            snd_l_d     = '0;
                            snd_r_d     = '0;
                            snd_valid_d = 1'b1;
                        end
                    end
                end
            end
            ST_POP: begin
                din_l_d = FIFO_DOUT_L;
                din_r_d = FIFO_DOUT_R;
                cnt_d   = LAT_M1;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                // The counter already runs here so the capture lands DP_LAT+1 cycles after the pop.
                dp_load = 1'b1;
                if (cnt_q == '0) begin
                    capture = 1'b1;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (capture) begin
            snd_l_d     = DP_SND_L;
            snd_r_d     = DP_SND_R;
            snd_valid_d = 1'b1;
            state_d     = ST_IDLE;
        end
    end

    // A tick arriving on the capture cycle is still an overrun; it is dropped.
    assign overrun = tick_en && (state_q != ST_IDLE);

    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            din_l_q     <= '0;
            din_r_q     <= '0;
            snd_l_q     <= '0;
            snd_r_q     <= '0;
            snd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            din_l_q     <= din_l_d;
            din_r_q     <= din_r_d;
            snd_l_q     <= snd_l_d;
            snd_r_q     <= snd_r_d;
            snd_valid_q <= snd_valid_d;
        end
    end

    assign FIFO_RD_EN = rd_en & RST_X;
    assign DP_LOAD    = dp_load & RST_X;
    assign BUSY       = (state_q != ST_IDLE) & RST_X;
    assign UNDERRUN   = underrun & RST_X;
    assign OVERRUN    = overrun & RST_X;
    assign DP_DIN_L   = din_l_q;
    assign DP_DIN_R   = din_r_q;
    assign L_SNDDATA  = snd_l_q;
    assign R_SNDDATA  = snd_r_q;
    assign SND_VALID  = snd_valid_q;

`ifdef SND_FFT_SEQ_STAT_EN
    logic [1:0]  stat_inc;
    logic [15:0] stat_cnt [2];

    assign stat_inc = {OVERRUN, UNDERRUN};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_stat
            snd_sat_cnt16 u_cnt (
                .clk_i   (CLK),
                .rst_n_i (RST_X),
                .clr_i   (1'b0),
                .inc_i   (stat_inc[gi]),
                .cnt_o   (stat_cnt[gi])
            );
        end
    endgenerate

    assign UNDERRUN_CNT = stat_cnt[0];
    assign OVERRUN_CNT  = stat_cnt[1];
`else
    assign UNDERRUN_CNT = 16'h0;
    assign OVERRUN_CNT  = 16'h0;
`endif

endmodule

// File: tb/tb_snd_fft_seq.sv
// Directed bench for snd_fft_seq: DP_LAT=6/no-mute instance plus a DP_LAT=1/mute instance.
module tb_snd_fft_seq;

    logic        CLK;
    logic        RST_X;
    logic        ENABLE;
    logic        SMP_TICK;
    logic        FIFO_EMPTY_L;
    logic        FIFO_EMPTY_R;
    logic [31:0] FIFO_DOUT_L;
    logic [31:0] FIFO_DOUT_R;
    logic [15:0] DP_SND_L;
    logic [15:0] DP_SND_R;

    logic        FIFO_RD_EN, DP_LOAD, SND_VALID, BUSY, UNDERRUN, OVERRUN;
    logic [31:0] DP_DIN_L, DP_DIN_R;
    logic [15:0] L_SNDDATA, R_SNDDATA, UNDERRUN_CNT, OVERRUN_CNT;

    logic        m_rd_en, m_load, m_valid, m_busy, m_under, m_over;
    logic [31:0] m_din_l, m_din_r;
    logic [15:0] m_l, m_r, m_ucnt, m_ocnt;

    localparam logic [31:0] WORD_L = 32'h0123_4567;
    localparam logic [31:0] WORD_R = 32'h89AB_CDEF;

    int   cyc = 0;
    logic snd_ovr = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    snd_fft_seq #(.DP_LAT(6), .MUTE_ON_UNDERRUN(0)) dut (
        .CLK(CLK), .RST_X(RST_X), .ENABLE(ENABLE), .SMP_TICK(SMP_TICK),
        .FIFO_EMPTY_L(FIFO_EMPTY_L), .FIFO_EMPTY_R(FIFO_EMPTY_R), .FIFO_RD_EN(FIFO_RD_EN),
        .FIFO_DOUT_L(FIFO_DOUT_L), .FIFO_DOUT_R(FIFO_DOUT_R),
        .DP_DIN_L(DP_DIN_L), .DP_DIN_R(DP_DIN_R), .DP_LOAD(DP_LOAD),
        .DP_SND_L(DP_SND_L), .DP_SND_R(DP_SND_R),
        .L_SNDDATA(L_SNDDATA), .R_SNDDATA(R_SNDDATA), .SND_VALID(SND_VALID),
        .BUSY(BUSY), .UNDERRUN(UNDERRUN), .OVERRUN(OVERRUN),
        .UNDERRUN_CNT(UNDERRUN_CNT), .OVERRUN_CNT(OVERRUN_CNT)
    );

    snd_fft_seq #(.DP_LAT(1), .MUTE_ON_UNDERRUN(1)) dut_m (
        .CLK(CLK), .RST_X(RST_X), .ENABLE(ENABLE), .SMP_TICK(SMP_TICK),
        .FIFO_EMPTY_L(FIFO_EMPTY_L), .FIFO_EMPTY_R(FIFO_EMPTY_R), .FIFO_RD_EN(m_rd_en),
        .FIFO_DOUT_L(FIFO_DOUT_L), .FIFO_DOUT_R(FIFO_DOUT_R),
        .DP_DIN_L(m_din_l), .DP_DIN_R(m_din_r), .DP_LOAD(m_load),
        .DP_SND_L(DP_SND_L), .DP_SND_R(DP_SND_R),
        .L_SNDDATA(m_l), .R_SNDDATA(m_r), .SND_VALID(m_valid),
        .BUSY(m_busy), .UNDERRUN(m_under), .OVERRUN(m_over),
        .UNDERRUN_CNT(m_ucnt), .OVERRUN_CNT(m_ocnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // FIFO read data is only meaningful the cycle after the pop.
    always @(posedge CLK) begin
        FIFO_DOUT_L <= FIFO_RD_EN ? WORD_L : 32'hDEAD_BEEF;
        FIFO_DOUT_R <= FIFO_RD_EN ? WORD_R : 32'hDEAD_BEEF;
    end

    // Datapath stand-in: result encodes the cycle it was sampled in.
    assign DP_SND_L = snd_ovr ? 16'h1234 : {8'hA5, cyc[7:0]};
    assign DP_SND_R = snd_ovr ? 16'h4321 : {8'h5A, ~cyc[7:0]};

    typedef struct {
        logic tick;
        logic rd;
        logic load;
        logic busy;
        logic vld;
        logic m_vld;
    } vec_t;

    vec_t tbl [10];

    task automatic step(input logic rst_n, input logic tick, input logic en,
                        input logic el, input logic er);
        @(negedge CLK);
        RST_X        = rst_n;
        SMP_TICK     = tick;
        ENABLE       = en;
        FIFO_EMPTY_L = el;
        FIFO_EMPTY_R = er;
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_l(input int c);
        logic [7:0] b;
        b = 8'(c);
        return {8'hA5, b};
    endfunction

    function automatic logic [15:0] exp_r(input int c);
        logic [7:0] b;
        b = 8'(c);
        return {8'h5A, ~b};
    endfunction

    int t0;
    int rd_cnt, ov_cnt, un_cnt, v_cnt;

    initial begin
        //            tick  rd    load  busy  vld   m_vld
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        RST_X = 1'b0; ENABLE = 1'b0; SMP_TICK = 1'b0;
        FIFO_EMPTY_L = 1'b0; FIFO_EMPTY_R = 1'b0;

        // Reset state
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        chk("rst rd_en", 32'(FIFO_RD_EN), 0);
        chk("rst busy", 32'(BUSY), 0);
        chk("rst load", 32'(DP_LOAD), 0);
        chk("rst valid", 32'(SND_VALID), 0);
        chk("rst din_l", DP_DIN_L, 0);
        chk("rst snd_l", 32'(L_SNDDATA), 0);
        chk("rst under", 32'(UNDERRUN), 0);
        chk("rst ucnt", 32'(UNDERRUN_CNT), 0);
        step(1, 0, 1, 0, 0);
        $display("reset done");

        // Frame 1: table-driven per-cycle sequence
        for (int i = 0; i < 10; i++) begin
            step(1, tbl[i].tick, 1, 0, 0);
            if (i == 0) t0 = cyc;
            chk($sformatf("f1 c%0d rd_en", i), 32'(FIFO_RD_EN), 32'(tbl[i].rd));
            chk($sformatf("f1 c%0d load", i), 32'(DP_LOAD), 32'(tbl[i].load));
            chk($sformatf("f1 c%0d busy", i), 32'(BUSY), 32'(tbl[i].busy));
            chk($sformatf("f1 c%0d valid", i), 32'(SND_VALID), 32'(tbl[i].vld));
            chk($sformatf("f1 c%0d m_valid", i), 32'(m_valid), 32'(tbl[i].m_vld));
            chk($sformatf("f1 c%0d under", i), 32'(UNDERRUN), 0);
            chk($sformatf("f1 c%0d over", i), 32'(OVERRUN), 0);
            if (tbl[i].load) begin
                chk("f1 din_l at load", DP_DIN_L, WORD_L);
                chk("f1 din_r at load", DP_DIN_R, WORD_R);
            end
            if (tbl[i].vld) begin
                chk("f1 snd_l", 32'(L_SNDDATA), 32'(exp_l(t0 + 7)));
                chk("f1 snd_r", 32'(R_SNDDATA), 32'(exp_r(t0 + 7)));
            end
            if (tbl[i].m_vld) begin
                chk("f1 m_snd_l", 32'(m_l), 32'(exp_l(t0 + 2)));
                chk("f1 m_din_l", m_din_l, WORD_L);
            end
        end
        chk("f1 din_l hold", DP_DIN_L, WORD_L);
        $display("frame1 L=%h R=%h", L_SNDDATA, R_SNDDATA);

        // Frame producing 16'h1234, then underruns
        snd_ovr = 1'b1;
        for (int c = 0; c < 10; c++) step(1, c == 0, 1, 0, 0);
        snd_ovr = 1'b0;
        chk("pre-underrun snd_l", 32'(L_SNDDATA), 32'h1234);
        chk("pre-underrun m_snd_l", 32'(m_l), 32'h1234);
        step(1, 1, 1, 0, 1);
        chk("under strobe", 32'(UNDERRUN), 1);
        chk("under no rd_en", 32'(FIFO_RD_EN), 0);
        chk("under m strobe", 32'(m_under), 1);
        step(1, 0, 1, 0, 0);
        chk("under no valid", 32'(SND_VALID), 0);
        chk("under hold l", 32'(L_SNDDATA), 32'h1234);
        chk("under busy", 32'(BUSY), 0);
        chk("mute valid", 32'(m_valid), 1);
        chk("mute l", 32'(m_l), 0);
        chk("mute r", 32'(m_r), 0);
        step(1, 1, 0, 1, 1);
        chk("disabled tick under", 32'(UNDERRUN), 0);
        step(1, 0, 1, 0, 0);
        chk("under later valid", 32'(SND_VALID), 0);
        $display("underrun L=%h mute L=%h", L_SNDDATA, m_l);

        // Overrun: ticks at c3 and on the capture cycle c7
        rd_cnt = 0; ov_cnt = 0; v_cnt = 0;
        for (int c = 0; c < 14; c++) begin
            step(1, (c == 0) || (c == 3) || (c == 7), 1, 0, 0);
            if (c == 0) t0 = cyc;
            rd_cnt += int'(FIFO_RD_EN);
            ov_cnt += int'(OVERRUN);
            v_cnt  += int'(SND_VALID);
            if (c == 3) chk("ovr c3 strobe", 32'(OVERRUN), 1);
            if (c == 7) chk("ovr c7 strobe", 32'(OVERRUN), 1);
            if (c == 8) begin
                chk("ovr c8 valid", 32'(SND_VALID), 1);
                chk("ovr snd_l", 32'(L_SNDDATA), 32'(exp_l(t0 + 7)));
            end
        end
        chk("ovr pops", rd_cnt, 1);
        chk("ovr strobes", ov_cnt, 2);
        chk("ovr valids", v_cnt, 1);
        $display("overrun pops=%0d overruns=%0d valids=%0d", rd_cnt, ov_cnt, v_cnt);

        // ENABLE dropped in cycle 4, then three ticks
        rd_cnt = 0; ov_cnt = 0; un_cnt = 0; v_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            step(1, (c == 0) || (c == 5) || (c == 6) || (c == 12), c < 4, 0, 0);
            rd_cnt += int'(FIFO_RD_EN);
            ov_cnt += int'(OVERRUN);
            un_cnt += int'(UNDERRUN);
            v_cnt  += int'(SND_VALID);
            if (c == 8) chk("en-drop c8 valid", 32'(SND_VALID), 1);
        end
        chk("en-drop pops", rd_cnt, 1);
        chk("en-drop overruns", ov_cnt, 0);
        chk("en-drop underruns", un_cnt, 0);
        chk("en-drop valids", v_cnt, 1);
        chk("en-drop idle", 32'(BUSY), 0);
        $display("enable-drop pops=%0d valids=%0d", rd_cnt, v_cnt);

`ifdef SND_FFT_SEQ_STAT_EN
        chk("stat ucnt", 32'(UNDERRUN_CNT), 1);
        chk("stat ocnt", 32'(OVERRUN_CNT), 2);
`else
        chk("nostat ucnt", 32'(UNDERRUN_CNT), 0);
        chk("nostat ocnt", 32'(OVERRUN_CNT), 0);
`endif

        // Reset during WAIT
        for (int c = 0; c < 4; c++) step(1, c == 0, 1, 0, 0);
        chk("abort in wait busy", 32'(BUSY), 1);
        step(0, 0, 1, 0, 0);
        chk("abort rst busy", 32'(BUSY), 0);
        step(1, 0, 1, 0, 0);
        chk("abort busy", 32'(BUSY), 0);
        chk("abort valid", 32'(SND_VALID), 0);
        chk("abort load", 32'(DP_LOAD), 0);
        chk("abort din_l", DP_DIN_L, 0);
        chk("abort din_r", DP_DIN_R, 0);
        chk("abort snd_l", 32'(L_SNDDATA), 0);
        chk("abort ocnt", 32'(OVERRUN_CNT), 0);
        v_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            step(1, 0, 1, 0, 0);
            v_cnt += int'(SND_VALID);
        end
        chk("abort no valid", v_cnt, 0);
        for (int c = 0; c < 10; c++) begin
            step(1, c == 0, 1, 0, 0);
            if (c == 0) t0 = cyc;
            if (c == 8) begin
                chk("post-abort valid", 32'(SND_VALID), 1);
                chk("post-abort snd_l", 32'(L_SNDDATA), 32'(exp_l(t0 + 7)));
                chk("post-abort din_r", DP_DIN_R, WORD_R);
            end
        end
        $display("post-abort frame L=%h", L_SNDDATA);

`ifdef SND_FFT_SEQ_STAT_EN
        // Saturation of the underrun counter
        for (int c = 0; c < 70000; c++) step(1, 1, 1, 1, 1);
        chk("sat ucnt", 32'(UNDERRUN_CNT), 32'hFFFF);
        step(0, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        chk("sat ucnt after reset", 32'(UNDERRUN_CNT), 0);
        $display("saturation test done");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
